// File: rtl/spi_frame_reader.sv
// rtl/spi_frame_reader.sv - SPI master that reads one 128-bit trigger frame per irq_n fall; optional OVERRUN_COUNT_EN adds overrun_count
module spi_frame_reader #(
    parameter int CLK_DIV  = 4,
    parameter int CS_GUARD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_n,
    output logic        spi_clk,
    output logic        spi_cs,
    input  logic        spi_si,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic [15:0] trig_id,
    output logic [47:0] trig_cycle,
    output logic        veto_flag,
    output logic        int_trig_flag,
    output logic [23:0] data,
    output logic        frame_error,
    output logic        busy
`ifdef OVERRUN_COUNT_EN
    ,
    output logic [7:0]  overrun_count
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_GUARD   = 3'd3;
    localparam logic [2:0] ST_PRESENT = 3'd4;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] GUARD_LAST = 16'(CS_GUARD - 1);
    localparam logic [7:0]  START_BYTE = 8'h7E;
    localparam logic [7:0]  END_BYTE   = 8'h7D;

    logic [2:0]   state;
    logic         irq_s1;
    logic         irq_s2;
    logic         irq_prev;
    logic [1:0]   arm_cnt;
    logic         irq_armed;
    logic         irq_fall;
    logic         si_s1;
    logic         si_s2;
    logic         pending;
    logic         start_xfer;
    logic [7:0]   div_cnt;
    logic [6:0]   bit_cnt;
    logic         bit_done;
    logic [15:0]  guard_cnt;
    logic         rise_pulse;
    logic         rise_d1;
    logic         rise_d2;
    logic [127:0] shift_reg;
    logic         unused_bits;

    // Two-flop synchronisers; irq_n idles high, spi_si idles low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
            si_s1  <= 1'b0;
            si_s2  <= 1'b0;
        end else begin
            irq_s1 <= irq_n;
            irq_s2 <= irq_s1;
            si_s1  <= spi_si;
            si_s2  <= si_s1;
        end
    end

    // Falling-edge detector, held off until the synchroniser has flushed its
    // reset value so a line already low at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev <= 1'b1;
            arm_cnt  <= 2'd0;
        end else begin
            irq_prev <= irq_s2;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    assign irq_armed  = (arm_cnt == 2'd3);
    assign irq_fall   = irq_armed & irq_prev & ~irq_s2;
    assign start_xfer = (state == ST_IDLE) && (irq_fall || pending);
    assign busy       = (state != ST_IDLE);

    // One-deep request memory for interrupts that arrive while a frame is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (start_xfer) begin
            pending <= 1'b0;
        end else if (irq_fall && (state != ST_IDLE)) begin
            pending <= 1'b1;
        end
    end

`ifdef OVERRUN_COUNT_EN
    // Counts interrupts folded into an already-pending request, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_count <= 8'd0;
        end else if (irq_fall && pending && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
        end
    end
`endif

    // Sequencer: chip select, SPI clock generation, guard time and frame hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            spi_cs        <= 1'b1;
            spi_clk       <= 1'b0;
            div_cnt       <= 8'd0;
            bit_cnt       <= 7'd0;
            bit_done      <= 1'b0;
            guard_cnt     <= 16'd0;
            rise_pulse    <= 1'b0;
            frame_valid   <= 1'b0;
            trig_id       <= 16'd0;
            trig_cycle    <= 48'd0;
            veto_flag     <= 1'b0;
            int_trig_flag <= 1'b0;
            data          <= 24'd0;
            frame_error   <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_xfer) begin
                        state   <= ST_SETUP;
                        spi_cs  <= 1'b0;
                        div_cnt <= 8'd0;
                    end
                end
                ST_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        state    <= ST_SHIFT;
                        div_cnt  <= 8'd0;
                        bit_cnt  <= 7'd0;
                        bit_done <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    // bit_done marks the 128th falling edge; cs rises one cycle later.
                    if (bit_done) begin
                        state     <= ST_GUARD;
                        spi_cs    <= 1'b1;
                        guard_cnt <= 16'd0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        if (!spi_clk) begin
                            spi_clk    <= 1'b1;
                            rise_pulse <= 1'b1;
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 7'd127) begin
                                bit_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state         <= ST_PRESENT;
                        frame_valid   <= 1'b1;
                        trig_id       <= shift_reg[119:104];
                        trig_cycle    <= shift_reg[87:40];
                        veto_flag     <= shift_reg[39];
                        int_trig_flag <= shift_reg[38];
                        data          <= shift_reg[31:8];
                        frame_error   <= (shift_reg[127:120] != START_BYTE) ||
                                         (shift_reg[7:0] != END_BYTE);
                    end else begin
                        guard_cnt <= guard_cnt + 16'd1;
                    end
                end
                ST_PRESENT: begin
                    if (frame_ack) begin
                        state       <= ST_IDLE;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    spi_cs      <= 1'b1;
                    spi_clk     <= 1'b0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

    // Capture delayed two cycles after each rising spi_clk so the synchronised
    // sample corresponds to the line value at the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_d1   <= 1'b0;
            rise_d2   <= 1'b0;
            shift_reg <= 128'd0;
        end else begin
            rise_d1 <= rise_pulse;
            rise_d2 <= rise_d1;
            if (rise_d2) begin
                shift_reg <= {shift_reg[126:0], si_s2};
            end
        end
    end

    // Reserved frame bits carry no decoded field.
    assign unused_bits = ^{shift_reg[103:88], shift_reg[37:32]};

endmodule

// File: tb/tb_spi_frame_reader.sv
// tb/tb_spi_frame_reader.sv - randomized self-checking bench for spi_frame_reader with slave and frame model
module tb_spi_frame_reader;

    localparam int CLK_DIV  = 4;
    localparam int CS_GUARD = 8;
    localparam logic [127:0] F_GOOD = {8'h7E, 16'h1234, 16'h0000, 48'h0000_00AB_CDEF,
                                       8'hC0, 24'hA5A5A5, 8'h7D};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq_n = 1'b1;
    logic        spi_si = 1'b0;
    logic        frame_ack = 1'b0;
    logic        spi_clk;
    logic        spi_cs;
    logic        frame_valid;
    logic [15:0] trig_id;
    logic [47:0] trig_cycle;
    logic        veto_flag;
    logic        int_trig_flag;
    logic [23:0] data;
    logic        frame_error;
    logic        busy;
`ifdef OVERRUN_COUNT_EN
    logic [7:0]  overrun_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [127:0] tx_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] cur;
    logic [127:0] expf;
    int idx = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int n_xfers = 0;
    int n_acked = 0;
    int cyc = 0;
    int t_cs_fall = 0;
    int t_last_rise = 0;
    int t_cs_rise = 0;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ack = 1'b0;

    spi_frame_reader #(.CLK_DIV(CLK_DIV), .CS_GUARD(CS_GUARD)) dut (
        .clk(clk),
        .reset(reset),
        .irq_n(irq_n),
        .spi_clk(spi_clk),
        .spi_cs(spi_cs),
        .spi_si(spi_si),
        .frame_valid(frame_valid),
        .frame_ack(frame_ack),
        .trig_id(trig_id),
        .trig_cycle(trig_cycle),
        .veto_flag(veto_flag),
        .int_trig_flag(int_trig_flag),
        .data(data),
        .frame_error(frame_error),
        .busy(busy)
`ifdef OVERRUN_COUNT_EN
        ,
        .overrun_count(overrun_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic frame_err(input logic [127:0] f);
        return (f[127:120] != 8'h7E) || (f[7:0] != 8'h7D);
    endfunction

    // Slave device, link timing observer and frame scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            check("reset_cs", 64'(spi_cs), 64'(1));
            check("reset_sclk", 64'(spi_clk), 64'(0));
            check("reset_valid", 64'(frame_valid), 64'(0));
            check("reset_busy", 64'(busy), 64'(0));
            exp_q.delete();
            spi_si = 1'b0;
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
            prev_valid = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_cs && !spi_cs) begin
                n_xfers++;
                rise_cnt = 0;
                fall_cnt = 0;
                t_cs_fall = cyc;
                if (tx_q.size() > 0) cur = tx_q.pop_front();
                else cur = {$urandom(), $urandom(), $urandom(), $urandom()};
                exp_q.push_back(cur);
                idx = 127;
                spi_si = cur[127];
            end
            if (!prev_sclk && spi_clk) begin
                rise_cnt++;
                check("rise_cs_low", 64'(spi_cs), 64'(0));
                if (rise_cnt == 1) check("setup_len", 64'(cyc - t_cs_fall), 64'(2 * CLK_DIV));
                else check("sclk_period", 64'(cyc - t_last_rise), 64'(2 * CLK_DIV));
                t_last_rise = cyc;
            end
            if (prev_sclk && !spi_clk) begin
                fall_cnt++;
                check("fall_cs_low", 64'(spi_cs), 64'(0));
                if (idx > 0) begin
                    idx--;
                    spi_si = cur[idx];
                end
            end
            if (spi_cs) check("sclk_idle_low", 64'(spi_clk), 64'(0));
            else check("busy_cs_low", 64'(busy), 64'(1));
            if (!prev_cs && spi_cs) begin
                check("rise_count", 64'(rise_cnt), 64'(128));
                check("fall_count", 64'(fall_cnt), 64'(128));
                t_cs_rise = cyc;
            end
            if (prev_valid && prev_ack) check("valid_clear_after_ack", 64'(frame_valid), 64'(0));
            if (frame_valid) begin
                if (!prev_valid) begin
                    check("frame_expected", 64'(exp_q.size() != 0), 64'(1));
                    check("guard_len", 64'(cyc - t_cs_rise), 64'(CS_GUARD));
                end
                if (exp_q.size() > 0) begin
                    expf = exp_q[0];
                    check("trig_id", 64'(trig_id), 64'(expf[119:104]));
                    check("trig_cycle", 64'(trig_cycle), 64'(expf[87:40]));
                    check("veto_flag", 64'(veto_flag), 64'(expf[39]));
                    check("int_trig_flag", 64'(int_trig_flag), 64'(expf[38]));
                    check("data", 64'(data), 64'(expf[31:8]));
                    check("frame_error", 64'(frame_error), 64'(frame_err(expf)));
                    if (frame_ack) begin
                        void'(exp_q.pop_front());
                        n_acked++;
                    end
                end
                check("busy_valid", 64'(busy), 64'(1));
            end
            prev_cs = spi_cs;
            prev_sclk = spi_clk;
            prev_valid = frame_valid;
            prev_ack = frame_ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic irq_pulse();
        irq_n = 1'b0;
        repeat (5) tick();
        irq_n = 1'b1;
        repeat (5) tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!frame_valid && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(frame_valid), 64'(1));
    endtask

    task automatic wait_shift_bit(input int xfer, input int bits, input string name);
        int n = 0;
        while (!(n_xfers == xfer && rise_cnt >= bits) && n < 3000) begin
            tick();
            n++;
        end
        check(name, 64'(n_xfers == xfer && rise_cnt >= bits), 64'(1));
    endtask

    // mode 0: random ack once valid, 1: ack held high, 2: ack toggles randomly
    task automatic run_until_acked(input int target, input int mode, input string name);
        int n = 0;
        while (n_acked < target && n < 4000) begin
            case (mode)
                0: frame_ack = frame_valid && ($urandom_range(0, 3) == 0);
                1: frame_ack = 1'b1;
                default: frame_ack = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        frame_ack = 1'b0;
        check(name, 64'(n_acked >= target), 64'(1));
    endtask

    initial begin
        logic [127:0] f;
        int bx;
        int ba;
        repeat (5) tick();
        check("rst_trig_id", 64'(trig_id), 64'(0));
        check("rst_trig_cycle", 64'(trig_cycle), 64'(0));
        check("rst_veto", 64'(veto_flag), 64'(0));
        check("rst_int_trig", 64'(int_trig_flag), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_frame_error", 64'(frame_error), 64'(0));
`ifdef OVERRUN_COUNT_EN
        check("rst_overrun", 64'(overrun_count), 64'(0));
`endif

        // irq_n already low at reset release must not start a frame
        irq_n = 1'b0;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        check("irq_low_at_release_xfers", 64'(n_xfers), 64'(0));
        check("irq_low_at_release_busy", 64'(busy), 64'(0));
        irq_n = 1'b1;
        repeat (10) tick();

        // acks while idle are ignored
        repeat (3) begin
            frame_ack = 1'b1;
            tick();
            frame_ack = 1'b0;
            repeat (3) tick();
        end
        check("idle_ack_busy", 64'(busy), 64'(0));
        check("idle_ack_valid", 64'(frame_valid), 64'(0));

        // reference frame with literal expectations
        tx_q.push_back(F_GOOD);
        irq_pulse();
        wait_valid("good_valid");
        check("good_trig_id", 64'(trig_id), 64'h1234);
        check("good_trig_cycle", 64'(trig_cycle), 64'hABCDEF);
        check("good_veto", 64'(veto_flag), 64'(1));
        check("good_int_trig", 64'(int_trig_flag), 64'(1));
        check("good_data", 64'(data), 64'hA5A5A5);
        check("good_error", 64'(frame_error), 64'(0));
        run_until_acked(1, 0, "good_ack");

        // bad start byte: still presented, waits for ack
        f = F_GOOD;
        f[127:120] = 8'h7F;
        tx_q.push_back(f);
        irq_pulse();
        wait_valid("bad_start_valid");
        repeat (50) tick();
        check("bad_start_hold_valid", 64'(frame_valid), 64'(1));
        check("bad_start_error", 64'(frame_error), 64'(1));
        check("bad_start_hold_id", 64'(trig_id), 64'h1234);
        run_until_acked(2, 0, "bad_start_ack");

        // bad end byte, ack held high the whole time
        f = F_GOOD;
        f[7:0] = 8'h7C;
        tx_q.push_back(f);
        irq_pulse();
        wait_valid("bad_end_valid");
        check("bad_end_error", 64'(frame_error), 64'(1));
        run_until_acked(3, 1, "bad_end_ack");

        // random frames with assorted ack behaviour
        for (int i = 0; i < 6; i++) begin
            f = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) begin
                f[127:120] = 8'h7E;
                f[7:0] = 8'h7D;
            end
            tx_q.push_back(f);
            irq_pulse();
            run_until_acked(n_acked + 1, i % 3, "rand_ack");
        end

        // three edges during shift merge into a single follow-up frame
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        bx = n_xfers;
        ba = n_acked;
        tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        tx_q.push_back(F_GOOD);
        irq_pulse();
        wait_shift_bit(bx + 1, 20, "merge_reach_shift");
        repeat (3) irq_pulse();
        run_until_acked(ba + 2, 2, "merge_ack");
        repeat (300) tick();
        check("merged_xfers", 64'(n_xfers - bx), 64'(2));
`ifdef OVERRUN_COUNT_EN
        check("overrun_count", 64'(overrun_count), 64'(2));
`endif

        // reset at bit 60 aborts; no partial frame, next frame is clean
        bx = n_xfers;
        ba = n_acked;
        tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        irq_pulse();
        wait_shift_bit(bx + 1, 60, "abort_reach_bit60");
        reset = 1'b1;
        repeat (4) tick();
        check("abort_cs_high", 64'(spi_cs), 64'(1));
        check("abort_sclk_low", 64'(spi_clk), 64'(0));
        reset = 1'b0;
        repeat (1500) tick();
        check("abort_no_valid", 64'(frame_valid), 64'(0));
        check("abort_no_ack", 64'(n_acked), 64'(ba));
        tx_q.push_back(F_GOOD);
        irq_pulse();
        wait_valid("post_abort_valid");
        check("post_abort_trig_id", 64'(trig_id), 64'h1234);
        check("post_abort_error", 64'(frame_error), 64'(0));
        run_until_acked(ba + 1, 0, "post_abort_ack");
        repeat (20) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
